// File: rtl/hpi_responder_if.sv
// Host Port Interface bus between the host-side HPI controller and the
// CY7C67200 (or the hpi_responder standing in for it).
interface hpi_responder_if;
  logic [1:0]  hpi_addr;
  logic        hpi_cs_n;
  logic        hpi_rd_n;
  logic        hpi_wr_n;
  logic [15:0] hpi_din;
  logic [15:0] hpi_dout;
  logic        hpi_oe;
  logic        hpi_int;

  modport master (output hpi_addr, hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_din,
                  input  hpi_dout, hpi_oe, hpi_int);
  modport slave  (input  hpi_addr, hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_din,
                  output hpi_dout, hpi_oe, hpi_int);
endinterface

// File: rtl/hpi_responder.sv
// CY7C67200 HPI chip-side emulation: word RAM, auto-incrementing address
// register, two mailboxes, status and INT, plus a local firmware-side port.
module hpi_responder #(
  parameter int MEM_AW = 8,
  parameter int MIN_RD = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  hpi_responder_if.slave    hpi,
  input  logic [MEM_AW-1:0] lcl_addr,
  input  logic              lcl_we,
  input  logic [15:0]       lcl_wdata,
  output logic [15:0]       lcl_rdata,
  output logic [15:0]       mbx_in_data,
  output logic              mbx_in_valid,
  input  logic              mbx_in_ack,
  input  logic [15:0]       mbx_out_data,
  input  logic              mbx_out_wr,
  output logic              mbx_out_busy
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_FETCH = 2'd1;
  localparam logic [1:0] RD_HOLD  = 2'd2;
  localparam logic [1:0] WR_HOLD  = 2'd3;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MBX  = 2'd1;
  localparam logic [1:0] A_ADDR = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  typedef struct packed {
    logic [1:0]  addr;
    logic        cs_n;
    logic        rd_n;
    logic        wr_n;
    logic [15:0] din;
  } hpi_req_t;

  hpi_req_t          s;
  logic              rd_act, wr_act;
  logic [1:0]        state;
  logic [1:0]        rd_sel, wr_sel;
  logic [15:0]       wr_data;
  logic [15:0]       addr_reg;
  logic [15:0]       dout_q;
  logic [15:0]       mbx_out_q;
  logic [7:0]        rd_len;
  logic [15:0]       mem [2**MEM_AW];
  logic [MEM_AW-1:0] widx;
  logic              wr_end, rd_end;
  logic              host_we, mbx_in_set, mbx_rd_end;

  // Sample stage is deliberately not reset: strobes still low when Reset
  // drops are seen as a fresh access on the first post-reset cycle.
  always_ff @(posedge Clk)
    s <= '{addr: hpi.hpi_addr, cs_n: hpi.hpi_cs_n, rd_n: hpi.hpi_rd_n,
           wr_n: hpi.hpi_wr_n, din: hpi.hpi_din};

  assign rd_act     = ~s.cs_n & ~s.rd_n;
  assign wr_act     = ~s.cs_n & ~s.wr_n;
  assign widx       = addr_reg[MEM_AW:1];

  assign wr_end     = (state == WR_HOLD) && !wr_act && !Reset;
  assign rd_end     = (state == RD_HOLD) && !rd_act && !Reset;
  assign host_we    = wr_end && (wr_sel == A_DATA);
  assign mbx_in_set = wr_end && (wr_sel == A_MBX);
  assign mbx_rd_end = rd_end && (rd_sel == A_MBX);

  assign hpi.hpi_dout = dout_q;
  assign hpi.hpi_oe   = ((state == RD_FETCH) || (state == RD_HOLD)) && rd_act;
  assign hpi.hpi_int  = mbx_out_busy;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      rd_sel   <= A_DATA;
      wr_sel   <= A_DATA;
      wr_data  <= '0;
      addr_reg <= '0;
      dout_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_act) begin
            state   <= WR_HOLD;
            wr_sel  <= s.addr;
            wr_data <= s.din;
          end else if (rd_act) begin
            state  <= RD_FETCH;
            rd_sel <= s.addr;
          end
        end
        RD_FETCH: begin
          state <= RD_HOLD;
          case (rd_sel)
            A_DATA:  dout_q <= mem[widx];
            A_MBX:   dout_q <= mbx_out_q;
            A_ADDR:  dout_q <= addr_reg;
            default: dout_q <= {14'b0, mbx_in_valid, mbx_out_busy};
          endcase
        end
        RD_HOLD: begin
          if (!rd_act) begin
            state <= IDLE;
            if (rd_sel == A_DATA) addr_reg <= addr_reg + 16'd2;
          end
        end
        WR_HOLD: begin
          // Keep tracking the bus until the strobe rises; commit what was
          // seen on the last active cycle.
          if (wr_act) begin
            wr_sel  <= s.addr;
            wr_data <= s.din;
          end else begin
            state <= IDLE;
            case (wr_sel)
              A_DATA:  addr_reg <= addr_reg + 16'd2;
              A_ADDR:  addr_reg <= wr_data;
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Host write is issued last so it wins a same-word collision.
  always_ff @(posedge Clk) begin
    if (lcl_we)  mem[lcl_addr] <= lcl_wdata;
    if (host_we) mem[widx]     <= wr_data;
  end

  always_ff @(posedge Clk) begin
    if (Reset) lcl_rdata <= '0;
    else       lcl_rdata <= mem[lcl_addr];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mbx_in_data  <= '0;
      mbx_in_valid <= 1'b0;
      mbx_out_q    <= '0;
      mbx_out_busy <= 1'b0;
    end else begin
      if (mbx_in_set) begin
        mbx_in_data  <= wr_data;
        mbx_in_valid <= 1'b1;
      end else if (mbx_in_ack) begin
        mbx_in_valid <= 1'b0;
      end
      // A fresh post beats the host draining the previous word.
      if (mbx_out_wr) begin
        mbx_out_q    <= mbx_out_data;
        mbx_out_busy <= 1'b1;
      end else if (mbx_rd_end) begin
        mbx_out_busy <= 1'b0;
      end
    end
  end

  // Length of the current read strobe as seen in the sample stage; a read
  // shorter than MIN_RD would let the host latch stale data.
  always_ff @(posedge Clk) begin
    if (Reset)
      rd_len <= '0;
    else if ((state == IDLE) && !wr_act && rd_act)
      rd_len <= 8'd1;
    else if (((state == RD_FETCH) || (state == RD_HOLD)) && rd_act && (rd_len != 8'hFF))
      rd_len <= rd_len + 8'd1;
  end

  always_ff @(posedge Clk)
    if (rd_end) assert (int'(rd_len) >= MIN_RD);

endmodule

// File: tb/tb_hpi_responder.sv
// Directed bench for hpi_responder: register map, mailboxes, collisions, reset.
module tb_hpi_responder;
  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MBX  = 2'd1;
  localparam logic [1:0] A_ADDR = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  lcl_addr = '0;
  logic        lcl_we = 1'b0;
  logic [15:0] lcl_wdata = '0;
  logic [15:0] lcl_rdata;
  logic [15:0] mbx_in_data;
  logic        mbx_in_valid;
  logic        mbx_in_ack = 1'b0;
  logic [15:0] mbx_out_data = '0;
  logic        mbx_out_wr = 1'b0;
  logic        mbx_out_busy;

  int checks = 0;
  int errors = 0;
  int oe_bad = 0;
  logic rd_n_q = 1'b1;
  logic cs_n_q = 1'b1;
  logic [15:0] r;

  hpi_responder_if hb();

  hpi_responder #(.MEM_AW(8), .MIN_RD(4)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .hpi          (hb),
    .lcl_addr     (lcl_addr),
    .lcl_we       (lcl_we),
    .lcl_wdata    (lcl_wdata),
    .lcl_rdata    (lcl_rdata),
    .mbx_in_data  (mbx_in_data),
    .mbx_in_valid (mbx_in_valid),
    .mbx_in_ack   (mbx_in_ack),
    .mbx_out_data (mbx_out_data),
    .mbx_out_wr   (mbx_out_wr),
    .mbx_out_busy (mbx_out_busy)
  );

  always #10 Clk = ~Clk;

  // oe must be low whenever the strobe was inactive at the last edge
  always @(posedge Clk) begin
    rd_n_q <= hb.hpi_rd_n;
    cs_n_q <= hb.hpi_cs_n;
  end
  always @(negedge Clk)
    if ((rd_n_q || cs_n_q) && hb.hpi_oe === 1'b1) oe_bad <= oe_bad + 1;

  task chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task wr_begin(input logic [1:0] a, input logic [15:0] d);
    @(negedge Clk);
    hb.hpi_addr = a; hb.hpi_din = d; hb.hpi_cs_n = 1'b0; hb.hpi_wr_n = 1'b0;
    repeat (3) @(negedge Clk);
    hb.hpi_wr_n = 1'b1; hb.hpi_cs_n = 1'b1;
  endtask

  task host_wr(input logic [1:0] a, input logic [15:0] d);
    wr_begin(a, d);
    repeat (3) @(negedge Clk);
  endtask

  task rd_begin(input logic [1:0] a, output logic [15:0] d);
    @(negedge Clk);
    hb.hpi_addr = a; hb.hpi_cs_n = 1'b0; hb.hpi_rd_n = 1'b0;
    repeat (6) @(negedge Clk);
    chk("oe_in_read", 16'(hb.hpi_oe), 16'd1);
    d = hb.hpi_dout;
    hb.hpi_rd_n = 1'b1; hb.hpi_cs_n = 1'b1;
  endtask

  task host_rd(input logic [1:0] a, output logic [15:0] d);
    rd_begin(a, d);
    repeat (3) @(negedge Clk);
  endtask

  task post(input logic [15:0] d);
    @(negedge Clk);
    mbx_out_data = d; mbx_out_wr = 1'b1;
    @(negedge Clk);
    mbx_out_wr = 1'b0;
  endtask

  task lcl_rd(input logic [7:0] a, output logic [15:0] d);
    @(negedge Clk);
    lcl_addr = a;
    @(negedge Clk);
    d = lcl_rdata;
  endtask

  task lcl_wr(input logic [7:0] a, input logic [15:0] d);
    @(negedge Clk);
    lcl_addr = a; lcl_wdata = d; lcl_we = 1'b1;
    @(negedge Clk);
    lcl_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks %0d", checks);
    $fatal(1);
  end

  initial begin
    hb.hpi_addr = 2'd0; hb.hpi_din = '0;
    hb.hpi_cs_n = 1'b1; hb.hpi_rd_n = 1'b1; hb.hpi_wr_n = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst_dout",   hb.hpi_dout, 16'h0000);
    chk("rst_oe",     16'(hb.hpi_oe), 16'd0);
    chk("rst_int",    16'(hb.hpi_int), 16'd0);
    chk("rst_in_vld", 16'(mbx_in_valid), 16'd0);
    chk("rst_busy",   16'(mbx_out_busy), 16'd0);
    chk("rst_lrdata", lcl_rdata, 16'h0000);
    Reset = 1'b0;
    host_rd(A_ADDR, r); chk("rst_addr", r, 16'h0000);

    // T1 auto-increment write/read
    host_wr(A_ADDR, 16'h0010);
    host_wr(A_DATA, 16'hBEEF);
    host_wr(A_DATA, 16'h1234);
    host_wr(A_ADDR, 16'h0010);
    host_rd(A_DATA, r); chk("t1_rd0", r, 16'hBEEF);
    host_rd(A_DATA, r); chk("t1_rd1", r, 16'h1234);
    host_rd(A_ADDR, r); chk("t1_addr", r, 16'h0014);
    lcl_rd(8'd8, r);    chk("t1_lcl8", r, 16'hBEEF);
    lcl_wr(8'd5, 16'h5A5A);
    host_wr(A_ADDR, 16'h000A);
    host_rd(A_DATA, r); chk("t1_lcl_to_host", r, 16'h5A5A);

    // T2 chip->host mailbox
    post(16'hA5A5);
    chk("t2_int", 16'(hb.hpi_int), 16'd1);
    host_rd(A_STAT, r); chk("t2_stat1", r, 16'h0001);
    host_rd(A_MBX, r);  chk("t2_mbx", r, 16'hA5A5);
    chk("t2_int_clr", 16'(hb.hpi_int), 16'd0);
    chk("t2_busy_clr", 16'(mbx_out_busy), 16'd0);
    host_rd(A_STAT, r); chk("t2_stat0", r, 16'h0000);

    // T3 host->chip mailbox, overwrite, ack collision
    host_wr(A_MBX, 16'h0042);
    chk("t3_vld", 16'(mbx_in_valid), 16'd1);
    chk("t3_data", mbx_in_data, 16'h0042);
    host_rd(A_STAT, r); chk("t3_stat", r, 16'h0002);
    host_wr(A_MBX, 16'h0043);
    chk("t3_ovw_data", mbx_in_data, 16'h0043);
    chk("t3_ovw_vld", 16'(mbx_in_valid), 16'd1);
    wr_begin(A_MBX, 16'h0044);
    @(negedge Clk); mbx_in_ack = 1'b1;
    @(negedge Clk); mbx_in_ack = 1'b0;
    chk("t3_ackcol_vld", 16'(mbx_in_valid), 16'd1);
    chk("t3_ackcol_data", mbx_in_data, 16'h0044);
    @(negedge Clk); mbx_in_ack = 1'b1;
    @(negedge Clk); mbx_in_ack = 1'b0;
    chk("t3_ack_vld", 16'(mbx_in_valid), 16'd0);
    host_wr(A_STAT, 16'hFFFF);
    host_rd(A_STAT, r); chk("t3_stat_wr_ign", r, 16'h0000);

    // T4 address wrap
    host_wr(A_ADDR, 16'hFFFE);
    host_wr(A_DATA, 16'h7777);
    host_rd(A_ADDR, r); chk("t4_wrap", r, 16'h0000);
    lcl_rd(8'd255, r);  chk("t4_lcl255", r, 16'h7777);

    // T5 host/local same-word write, post vs mailbox read end
    host_wr(A_ADDR, 16'h0006);
    wr_begin(A_DATA, 16'h1111);
    @(negedge Clk); lcl_addr = 8'd3; lcl_wdata = 16'h2222; lcl_we = 1'b1;
    @(negedge Clk); lcl_we = 1'b0;
    repeat (2) @(negedge Clk);
    lcl_rd(8'd3, r);    chk("t5_collide", r, 16'h1111);
    host_rd(A_ADDR, r); chk("t5_addr", r, 16'h0008);
    post(16'h1111);
    rd_begin(A_MBX, r); chk("t5_mbx_first", r, 16'h1111);
    @(negedge Clk); mbx_out_data = 16'hC3C3; mbx_out_wr = 1'b1;
    @(negedge Clk); mbx_out_wr = 1'b0;
    chk("t5_busy_kept", 16'(mbx_out_busy), 16'd1);
    chk("t5_int_kept", 16'(hb.hpi_int), 16'd1);
    repeat (2) @(negedge Clk);
    chk("t5_busy_later", 16'(mbx_out_busy), 16'd1);
    host_rd(A_MBX, r);  chk("t5_mbx_second", r, 16'hC3C3);
    chk("t5_busy_clr", 16'(mbx_out_busy), 16'd0);

    // T6 reset in the middle of a DATA write
    host_wr(A_ADDR, 16'h0020);
    host_wr(A_DATA, 16'h0BAD);
    host_wr(A_ADDR, 16'h0020);
    @(negedge Clk);
    hb.hpi_addr = A_DATA; hb.hpi_din = 16'hDEAD; hb.hpi_cs_n = 1'b0; hb.hpi_wr_n = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("t6_rst_oe", 16'(hb.hpi_oe), 16'd0);
    chk("t6_rst_dout", hb.hpi_dout, 16'h0000);
    hb.hpi_wr_n = 1'b1; hb.hpi_cs_n = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    chk("t6_oe", 16'(hb.hpi_oe), 16'd0);
    host_rd(A_ADDR, r);  chk("t6_addr", r, 16'h0000);
    lcl_rd(8'h10, r);    chk("t6_ram", r, 16'h0BAD);

    repeat (2) @(negedge Clk);
    chk("oe_while_rdn_hi", 16'(oe_bad), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
